// File: rtl/serial_port_fifo.sv
// serial_port_fifo: buffered 8N1 UART with TX/RX FIFOs, sticky error flags and RX threshold interrupt.
module sp_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [7:0]  din_i,
  output logic [7:0]  dout_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);
  logic [7:0]  mem_q [2**AW];
  logic [AW:0] wp_q, rp_q;
  logic        do_push, do_pop;
  assign full_o  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign empty_o = wp_q == rp_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = wp_q - rp_q;
  assign dout_o  = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + (AW+1)'(1);
      if (do_pop)  rp_q <= rp_q + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
endmodule

module serial_port_fifo #(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD          = 115200,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int RX_THRESHOLD  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  output logic                   wr_full,
  output logic [TX_DEPTH_LOG2:0] tx_count,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ack,
  output logic [RX_DEPTH_LOG2:0] rx_count,
  output logic                   overrun,
  output logic                   frame_err,
  output logic                   int_req,
  input  logic                   int_ack,
  output logic                   com_TxD,
  input  logic                   com_RxD
);
  localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [CW-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]     tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_head;
  logic           txd_q, txd_d, meta_q, s_q, arm_q, arm_d;
  logic           ovr_q, ovr_d, fe_q, fe_d;
  logic           tx_pop, tx_empty, tx_done, rx_done, rx_push, rx_full, rx_empty, fe_set;
  sp_fifo #(.AW(TX_DEPTH_LOG2)) u_txf (
    .clk(clk), .rst(rst), .push_i(wr_en), .pop_i(tx_pop), .din_i(wr_data),
    .dout_o(tx_head), .count_o(tx_count), .full_o(wr_full), .empty_o(tx_empty)
  );
  sp_fifo #(.AW(RX_DEPTH_LOG2)) u_rxf (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rd_ack), .din_i(rx_sh_q),
    .dout_o(rd_data), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
  );
  assign tx_done   = tx_cnt_q == '0;
  assign rx_done   = rx_cnt_q == '0;
  assign com_TxD   = txd_q;
  assign rd_valid  = !rx_empty;
  assign overrun   = ovr_q;
  assign frame_err = fe_q;
  assign int_req   = (rx_count >= (RX_DEPTH_LOG2+1)'(RX_THRESHOLD)) | ovr_q | fe_q;
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = (tx_st_q == IDLE || tx_done) ? CW'(DIV - 1) : tx_cnt_q - CW'(1);
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      IDLE:  if (!tx_empty) begin
        tx_pop  = 1'b1;
        tx_sh_d = tx_head;
        tx_st_d = START;
      end
      START: if (tx_done) begin
        tx_bit_d = '0;
        tx_st_d  = DATA;
      end
      DATA:  if (tx_done) begin
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d  = tx_bit_q == 3'd7 ? STOP : DATA;
      end
      STOP:  if (tx_done) begin
        tx_pop  = !tx_empty;
        tx_sh_d = tx_empty ? tx_sh_q : tx_head;
        tx_st_d = tx_empty ? IDLE : START;
      end
    endcase
    // line is registered from the current state, so it trails the FSM by one cycle
    txd_d = tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[0] : 1'b1;
  end
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_done ? CW'(DIV - 1) : rx_cnt_q - CW'(1);
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    arm_d    = arm_q;
    rx_push  = 1'b0;
    fe_set   = 1'b0;
    case (rx_st_q)
      IDLE:  if (!arm_q) arm_d = s_q;
             else if (!s_q) begin
               rx_st_d  = START;
               rx_cnt_d = CW'(DIV / 2);
             end
      START: if (rx_done) begin
        rx_bit_d = '0;
        rx_st_d  = s_q ? IDLE : DATA;
      end
      DATA:  if (rx_done) begin
        rx_sh_d  = {s_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d  = rx_bit_q == 3'd7 ? STOP : DATA;
      end
      STOP:  if (rx_done) begin
        rx_push = s_q;
        fe_set  = !s_q;
        arm_d   = s_q;
        rx_st_d = IDLE;
      end
    endcase
    ovr_d = (rx_push & rx_full) | (ovr_q & ~int_ack);
    fe_d  = fe_set | (fe_q & ~int_ack);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st_q  <= IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      txd_q    <= 1'b1;
      rx_st_q  <= IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      meta_q   <= 1'b1;
      s_q      <= 1'b1;
      arm_q    <= 1'b1;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      txd_q    <= txd_d;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      meta_q   <= com_RxD;
      s_q      <= meta_q;
      arm_q    <= arm_d;
      ovr_q    <= ovr_d;
      fe_q     <= fe_d;
    end
endmodule
